// File: rtl/spi_pkg.sv
// Shared state encoding and default constants for the SPI requester arbiter.
package spi_pkg;

    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_TIMEOUT_CYCLES = 8192;
    localparam int DEF_GAP_CYCLES     = 100;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_GAP    = 2'd3
    } arb_state_t;

    // Counter/index width that never collapses to zero bits for tiny limits.
    function automatic int cnt_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner selection: first set request at or after ptr, wrapping.
module rr_pick
    import spi_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = cnt_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                onehot[cand] = 1'b1;
                idx          = cand;
                any          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NUM_REQ requesters: round-robin grant, launch,
// completion or timeout response, then an enforced idle gap.
module spi_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int GAP_CYCLES     = DEF_GAP_CYCLES
) (
    input  logic                          clk,
    input  logic                          srst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [NUM_REQ-1:0]            cs_sel,
    output logic                          spi_m_start,
    output logic [DATA_WIDTH-1:0]         data_m_send,
    input  logic                          spi_m_done,
    input  logic [DATA_WIDTH-1:0]         data_m_recv
);

    localparam int IDX_W = cnt_width(NUM_REQ);
    localparam int TMR_W = cnt_width(TIMEOUT_CYCLES);
    localparam int GAP_W = cnt_width(GAP_CYCLES);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    arb_state_t            state, state_n;
    logic [IDX_W-1:0]      last_owner, last_owner_n;
    logic [IDX_W-1:0]      rr_ptr, pick_idx;
    logic [NUM_REQ-1:0]    pick_onehot;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] pick_data;
    logic [TMR_W-1:0]      timer, timer_n;
    logic [GAP_W-1:0]      gap_cnt, gap_cnt_n;
    logic [NUM_REQ-1:0]    gnt_n, rsp_valid_n, cs_sel_n;
    logic [DATA_WIDTH-1:0] rsp_data_n, data_m_send_n;
    logic                  rsp_err_n, spi_m_start_n;

    assign rr_ptr = (last_owner == LAST_IDX) ? '0 : last_owner + 1'b1;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req    (req),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_onehot[i]) begin
                pick_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // cs_sel doubles as the owner one-hot, so the response is steered from it.
    always_comb begin
        state_n       = state;
        last_owner_n  = last_owner;
        timer_n       = timer;
        gap_cnt_n     = gap_cnt;
        gnt_n         = '0;
        rsp_valid_n   = '0;
        rsp_data_n    = '0;
        rsp_err_n     = 1'b0;
        cs_sel_n      = cs_sel;
        spi_m_start_n = 1'b0;
        data_m_send_n = data_m_send;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_n         = pick_onehot;
                    cs_sel_n      = pick_onehot;
                    spi_m_start_n = 1'b1;
                    data_m_send_n = pick_data;
                    last_owner_n  = pick_idx;
                    state_n       = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                timer_n = '0;
                state_n = ST_BUSY;
            end
            ST_BUSY: begin
                // A done arriving on the expiry cycle still counts as success.
                if (spi_m_done || timer == TMR_LAST) begin
                    rsp_valid_n = cs_sel;
                    rsp_data_n  = spi_m_done ? data_m_recv : '0;
                    rsp_err_n   = !spi_m_done;
                    cs_sel_n    = '0;
                    gap_cnt_n   = '0;
                    state_n     = ST_GAP;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            ST_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_n = ST_IDLE;
                end else begin
                    gap_cnt_n = gap_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state       <= ST_IDLE;
            last_owner  <= LAST_IDX;
            timer       <= '0;
            gap_cnt     <= '0;
            gnt         <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            cs_sel      <= '0;
            spi_m_start <= 1'b0;
            data_m_send <= '0;
        end else begin
            state       <= state_n;
            last_owner  <= last_owner_n;
            timer       <= timer_n;
            gap_cnt     <= gap_cnt_n;
            gnt         <= gnt_n;
            rsp_valid   <= rsp_valid_n;
            rsp_data    <= rsp_data_n;
            rsp_err     <= rsp_err_n;
            cs_sel      <= cs_sel_n;
            spi_m_start <= spi_m_start_n;
            data_m_send <= data_m_send_n;
        end
    end

endmodule

// File: tb/tb_spi_arbiter.sv
// Directed self-checking bench for spi_arbiter with default parameters.
module tb_spi_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TO  = 8192;
    localparam int GAP = 100;

    logic             clk = 1'b0;
    logic             srst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] req_data;
    logic [NR-1:0]    gnt;
    logic [NR-1:0]    rsp_valid;
    logic [DW-1:0]    rsp_data;
    logic             rsp_err;
    logic [NR-1:0]    cs_sel;
    logic             spi_m_start;
    logic [DW-1:0]    data_m_send;
    logic             spi_m_done;
    logic [DW-1:0]    data_m_recv;

    int checks = 0;
    int errors = 0;

    spi_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO),
        .GAP_CYCLES     (GAP)
    ) dut (
        .clk         (clk),
        .srst        (srst),
        .req         (req),
        .req_data    (req_data),
        .gnt         (gnt),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .cs_sel      (cs_sel),
        .spi_m_start (spi_m_start),
        .data_m_send (data_m_send),
        .spi_m_done  (spi_m_done),
        .data_m_recv (data_m_recv)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Bounded wait for a grant; reports cycles waited and whether cs_sel stayed low.
    task automatic waitGnt(output int n, output logic cs_low);
        n = 0;
        cs_low = 1'b1;
        while (gnt == '0 && n < GAP + 20) begin
            if (cs_sel != '0) cs_low = 1'b0;
            tick();
            n++;
        end
        checkOutput("gnt_seen", 32'(gnt != '0), 32'd1);
    endtask

    // Called on the grant cycle: checks launch, returns done, checks response.
    task automatic doTxn(input logic [NR-1:0] exp_gnt, input logic [DW-1:0] exp_send, input logic [DW-1:0] recv);
        checkOutput("gnt", 32'(gnt), 32'(exp_gnt));
        checkOutput("send", 32'(data_m_send), 32'(exp_send));
        checkOutput("start", 32'(spi_m_start), 32'd1);
        checkOutput("cs_launch", 32'(cs_sel), 32'(exp_gnt));
        tick();
        checkOutput("start_pulse", 32'(spi_m_start), 32'd0);
        checkOutput("gnt_pulse", 32'(gnt), 32'd0);
        checkOutput("cs_busy", 32'(cs_sel), 32'(exp_gnt));
        spi_m_done  = 1'b1;
        data_m_recv = recv;
        tick();
        spi_m_done  = 1'b0;
        data_m_recv = '0;
        checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_gnt));
        checkOutput("rsp_data", 32'(rsp_data), 32'(recv));
        checkOutput("rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("cs_gap", 32'(cs_sel), 32'd0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        checkOutput({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        checkOutput({tag, "_cs_sel"}, 32'(cs_sel), 32'd0);
        checkOutput({tag, "_start"}, 32'(spi_m_start), 32'd0);
        checkOutput({tag, "_send"}, 32'(data_m_send), 32'd0);
    endtask

    task automatic applyStimulus();
        int   n;
        int   c;
        logic cs_low;
        logic flag;

        // Reset state
        srst = 1'b1; req = '0; req_data = '0; spi_m_done = 1'b0; data_m_recv = '0;
        tick(); tick();
        srst = 1'b0;
        checkAllZero("reset");

        // Single transaction from requester 0
        req = 4'b0001; req_data = 32'h0000_00ab;
        waitGnt(n, cs_low);
        checkOutput("single_latency", 32'(n), 32'd1);
        req = '0;
        doTxn(4'b0001, 8'hab, 8'hcd);

        // Reset again so the round-robin starts from requester 0
        srst = 1'b1; tick(); srst = 1'b0;
        req = 4'b1111; req_data = 32'h4433_2211;
        for (int k = 0; k < 5; k++) begin
            waitGnt(n, cs_low);
            checkOutput("rr_wait", 32'(n), (k == 0) ? 32'd1 : 32'(GAP + 1));
            if (k > 0) checkOutput("rr_gap_cs", 32'(cs_low), 32'd1);
            doTxn(4'(4'b0001 << (k % 4)), 8'((k % 4 + 1) * 17), 8'(8'h60 + k));
        end
        req = '0;

        // Stray done during GAP, then a request dropped before it could be granted
        tick();
        spi_m_done = 1'b1; tick(); spi_m_done = 1'b0;
        checkOutput("stray_gap", 32'(rsp_valid), 32'd0);
        req = 4'b0001; tick(); req = '0;
        flag = 1'b0;
        for (int k = 0; k < GAP + 5; k++) begin
            tick();
            if (gnt != '0 || rsp_valid != '0) flag = 1'b1;
        end
        checkOutput("dropped_req", 32'(flag), 32'd0);
        spi_m_done = 1'b1; tick(); spi_m_done = 1'b0;
        checkOutput("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        checkOutput("stray_idle_gnt", 32'(gnt), 32'd0);
        req = 4'b0010; req_data = 32'h0000_ffee;
        waitGnt(n, cs_low);
        checkOutput("after_stray_latency", 32'(n), 32'd1);
        req = '0;
        doTxn(4'b0010, 8'hff, 8'hff);

        // Timeout: requester 2, master never answers
        req = 4'b0100; req_data = 32'h005a_0000;
        waitGnt(n, cs_low);
        checkOutput("to_wait", 32'(n), 32'(GAP + 1));
        req = '0;
        checkOutput("to_gnt", 32'(gnt), 32'h4);
        checkOutput("to_send", 32'(data_m_send), 32'h5a);
        checkOutput("to_start", 32'(spi_m_start), 32'd1);
        c = 0; flag = 1'b1;
        while (rsp_valid == '0 && c < TO + 20) begin
            tick();
            c++;
            if (rsp_valid == '0 && cs_sel !== 4'b0100) flag = 1'b0;
        end
        checkOutput("to_latency", 32'(c), 32'(TO + 1));
        checkOutput("to_cs_held", 32'(flag), 32'd1);
        checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h4);
        checkOutput("to_rsp_err", 32'(rsp_err), 32'd1);
        checkOutput("to_rsp_data", 32'(rsp_data), 32'd0);

        // Done coincident with the expiry cycle counts as success
        req = 4'b0001; req_data = 32'h0000_00c3;
        waitGnt(n, cs_low);
        checkOutput("edge_wait", 32'(n), 32'(GAP + 1));
        req = '0;
        checkOutput("edge_gnt", 32'(gnt), 32'h1);
        repeat (TO) tick();
        checkOutput("edge_no_early", 32'(rsp_valid), 32'd0);
        spi_m_done = 1'b1; data_m_recv = 8'h3c;
        tick();
        spi_m_done = 1'b0; data_m_recv = '0;
        checkOutput("edge_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("edge_rsp_err", 32'(rsp_err), 32'd0);
        checkOutput("edge_rsp_data", 32'(rsp_data), 32'h3c);

        // Reset during BUSY of requester 3
        req = 4'b1000; req_data = 32'h7700_0000;
        waitGnt(n, cs_low);
        checkOutput("abort_wait", 32'(n), 32'(GAP + 1));
        req = '0;
        checkOutput("abort_gnt", 32'(gnt), 32'h8);
        checkOutput("abort_send", 32'(data_m_send), 32'h77);
        tick(); tick(); tick();
        checkOutput("abort_cs_busy", 32'(cs_sel), 32'h8);
        srst = 1'b1; tick(); srst = 1'b0;
        checkAllZero("abort");
        flag = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (rsp_valid != '0) flag = 1'b1;
            tick();
        end
        checkOutput("abort_no_rsp", 32'(flag), 32'd0);

        // After reset requester 0 wins over 3, then 3 is served next
        req = 4'b1001; req_data = 32'h8800_0099;
        waitGnt(n, cs_low);
        checkOutput("post_reset_wait", 32'(n), 32'd1);
        doTxn(4'b0001, 8'h99, 8'h12);
        waitGnt(n, cs_low);
        checkOutput("post_reset_wait2", 32'(n), 32'(GAP + 1));
        req = '0;
        doTxn(4'b1000, 8'h88, 8'h34);
    endtask

    initial begin
        applyStimulus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
